loop_counter_reg: RTL and testbench



---
 rtl/loop_counter_pkg.sv | 17 +
 rtl/step_addsub.sv | 45 ++++
 rtl/loop_counter_reg.sv | 109 ++++++++++
 tb/tb_loop_counter_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/loop_counter_pkg.sv
// loop_counter_pkg: shared definitions for the loop counter register.
//   - op_e: operation code from the top-level priority decode.
//   - DEFAULT_WIDTH / DEFAULT_STEP_W: default parameter values.
// Optional feature macro: LOOP_COUNTER_SAT_EN (saturating arithmetic).
package loop_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_STEP_W = 4;

endpackage

// File: rtl/step_addsub.sv
// step_addsub: combinational add/subtract of a zero-extended step.
//   a_i      WIDTH   operand (current count)
//   step_i   STEP_W  unsigned step magnitude
//   sub_i    1       1 = a - step, 0 = a + step
//   res_o    WIDTH   result (wrapped, or clamped when saturating)
//   flag_o   1       carry out on add, borrow on subtract
// Optional feature macro: LOOP_COUNTER_SAT_EN clamps the result on carry/borrow.
module step_addsub
  import loop_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STEP_W = DEFAULT_STEP_W
) (
  input  logic [WIDTH-1:0]  a_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              sub_i,
  output logic [WIDTH-1:0]  res_o,
  output logic              flag_o
);

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    step_ext               = '0;
    step_ext[STEP_W-1:0]   = step_i;
    // One extra bit: its MSB is the carry on add and the sign (borrow) on subtract.
    if (sub_i) begin
      sum = {1'b0, a_i} - step_ext;
    end else begin
      sum = {1'b0, a_i} + step_ext;
    end
    flag_o = sum[WIDTH];
`ifdef LOOP_COUNTER_SAT_EN
    if (sum[WIDTH]) begin
      res_o = sub_i ? '0 : '1;
    end else begin
      res_o = sum[WIDTH-1:0];
    end
`else
    res_o = sum[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/loop_counter_reg.sv
// loop_counter_reg: loadable up/down counter with zero, terminal-count and
// sticky overflow flags. All outputs are registered.
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   load   load din (highest priority)
//   din    load value
//   inc    count += step
//   dec    count -= step
//   step   unsigned step magnitude
//   count  registered counter value
//   zero   high when count == 0
//   tc     one-cycle pulse when a decrement lands exactly on zero
//   ovf    sticky carry/borrow flag, cleared by load or reset
// Optional feature macro: LOOP_COUNTER_SAT_EN (saturate instead of wrap).
module loop_counter_reg
  import loop_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STEP_W = DEFAULT_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              zero,
  output logic              tc,
  output logic              ovf
);

  op_e              op;
  logic [WIDTH-1:0] count_d, count_q;
  logic             zero_d, zero_q;
  logic             tc_d, tc_q;
  logic             ovf_d, ovf_q;
  logic [WIDTH-1:0] as_res;
  logic             as_flag;

  // Priority decode; conflicting inc/dec or a zero step is a hold.
  always_comb begin
    if (load) begin
      op = OP_LOAD;
    end else if (inc && !dec && (step != '0)) begin
      op = OP_INC;
    end else if (dec && !inc && (step != '0)) begin
      op = OP_DEC;
    end else begin
      op = OP_HOLD;
    end
  end

  step_addsub #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step_addsub (
    .a_i    (count_q),
    .step_i (step),
    .sub_i  (op == OP_DEC),
    .res_o  (as_res),
    .flag_o (as_flag)
  );

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    tc_d    = 1'b0;
    unique case (op)
      OP_LOAD: begin
        count_d = din;
        ovf_d   = 1'b0;
      end
      OP_INC: begin
        count_d = as_res;
        ovf_d   = ovf_q | as_flag;
      end
      OP_DEC: begin
        count_d = as_res;
        ovf_d   = ovf_q | as_flag;
        // A borrow (wrap or clamp to zero) never counts as reaching terminal count.
        tc_d    = (count_q != '0) && (as_res == '0) && !as_flag;
      end
      default: ;
    endcase
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      zero_q  <= 1'b1;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign zero  = zero_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_loop_counter_reg.sv
// Directed table-driven bench for loop_counter_reg (WIDTH=16, STEP_W=4).
// Expectations follow LOOP_COUNTER_SAT_EN when it is defined.
module tb_loop_counter_reg;

`ifdef LOOP_COUNTER_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic        inc;
  logic        dec;
  logic [3:0]  step;
  logic [15:0] count;
  logic        zero;
  logic        tc;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        load;
    logic [15:0] din;
    logic        inc;
    logic        dec;
    logic [3:0]  step;
    logic [15:0] e_count;
    logic        e_zero;
    logic        e_tc;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  loop_counter_reg #(
    .WIDTH  (16),
    .STEP_W (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .inc   (inc),
    .dec   (dec),
    .step  (step),
    .count (count),
    .zero  (zero),
    .tc    (tc),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] c, input logic z, input logic t,
                         input logic o);
    chk({name, ".count"}, count, c);
    chk({name, ".zero"}, {15'd0, zero}, {15'd0, z});
    chk({name, ".tc"}, {15'd0, tc}, {15'd0, t});
    chk({name, ".ovf"}, {15'd0, ovf}, {15'd0, o});
  endtask

  task automatic add(input string n, input logic l, input logic [15:0] d, input logic i,
                     input logic de, input logic [3:0] s, input logic [15:0] c, input logic z,
                     input logic t, input logic o);
    vec_t v;
    v.name = n; v.load = l; v.din = d; v.inc = i; v.dec = de; v.step = s;
    v.e_count = c; v.e_zero = z; v.e_tc = t; v.e_ovf = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic l, input logic [15:0] d, input logic i, input logic de,
                       input logic [3:0] s);
    load = l; din = d; inc = i; dec = de; step = s;
  endtask

  initial begin
    // name, load, din, inc, dec, step -> count, zero, tc, ovf
    add("load5",     1, 16'd5,     0, 0, 0, 16'd5, 0, 0, 0);
    add("load3",     1, 16'd3,     0, 0, 0, 16'd3, 0, 0, 0);
    add("dn2",       0, 16'd0,     0, 1, 1, 16'd2, 0, 0, 0);
    add("dn1",       0, 16'd0,     0, 1, 1, 16'd1, 0, 0, 0);
    add("dn0_tc",    0, 16'd0,     0, 1, 1, 16'd0, 1, 1, 0);
    add("hold_tc0",  0, 16'd0,     0, 0, 0, 16'd0, 1, 0, 0);
    add("ldFFFE",    1, 16'hFFFE,  0, 0, 0, 16'hFFFE, 0, 0, 0);
    add("inc_ovf",   0, 16'd0,     1, 0, 3, Sat ? 16'hFFFF : 16'h0001, 0, 0, 1);
    add("dec_after", 0, 16'd0,     0, 1, 1, Sat ? 16'hFFFE : 16'h0000, !Sat, !Sat, 1);
    add("both_hold", 0, 16'd0,     1, 1, 2, Sat ? 16'hFFFE : 16'h0000, !Sat, 0, 1);
    add("ld9_pri",   1, 16'd9,     1, 1, 5, 16'd9, 0, 0, 0);
    add("both9",     0, 16'd0,     1, 1, 1, 16'd9, 0, 0, 0);
    add("dec_s0",    0, 16'd0,     0, 1, 0, 16'd9, 0, 0, 0);
    add("load2",     1, 16'd2,     0, 0, 0, 16'd2, 0, 0, 0);
    add("dec_unf",   0, 16'd0,     0, 1, 5, Sat ? 16'h0000 : 16'hFFFD, Sat, 0, 1);
    add("ldFFFD",    1, 16'hFFFD,  0, 0, 0, 16'hFFFD, 0, 0, 0);
    add("inc7",      0, 16'd0,     1, 0, 7, Sat ? 16'hFFFF : 16'h0004, 0, 0, 1);
    add("inc15",     0, 16'd0,     1, 0, 15, Sat ? 16'hFFFF : 16'h0013, 0, 0, 1);
    add("dec15",     0, 16'd0,     0, 1, 15, Sat ? 16'hFFF0 : 16'h0004, 0, 0, 1);
    add("load0",     1, 16'd0,     0, 0, 0, 16'd0, 1, 0, 0);
    add("dec0_s0",   0, 16'd0,     0, 1, 0, 16'd0, 1, 0, 0);
    add("inc15b",    0, 16'd0,     1, 0, 15, 16'd15, 0, 0, 0);
    add("dec15_tc",  0, 16'd0,     0, 1, 15, 16'd0, 1, 1, 0);
    add("dec_from0", 0, 16'd0,     0, 1, 1, Sat ? 16'h0000 : 16'hFFFF, Sat, 0, 1);

    rst = 1'b1;
    drive(0, 16'd0, 0, 0, 0);
    #1;
    chk_all("reset", 16'd0, 1, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("idle", 16'd0, 1, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].load, vecs[k].din, vecs[k].inc, vecs[k].dec, vecs[k].step);
      @(posedge clk);
      #1;
      chk_all(vecs[k].name, vecs[k].e_count, vecs[k].e_zero, vecs[k].e_tc, vecs[k].e_ovf);
    end

    // Asynchronous reset between edges, with ovf set, then first command after release.
    drive(1, 16'd7, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 16'd0, 0, 1, 8);
    @(posedge clk);
    #1;
    chk_all("pre_rst", Sat ? 16'h0000 : 16'hFFFF, Sat, 0, 1);
    drive(1, 16'd7, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 16'd0, 0, 0, 0);
    chk_all("cnt7", 16'd7, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 16'd0, 1, 0, 0);
    drive(0, 16'd0, 1, 0, 4);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst_inc", 16'd4, 0, 0, 0);
    drive(0, 16'd0, 0, 1, 4);
    @(posedge clk);
    #1;
    chk_all("post_rst_tc", 16'd0, 1, 1, 0);
    drive(0, 16'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("tc_one_cycle", 16'd0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
